ripple_count_capture: RTL

- Downstream consumer of the 4-bit asynchronous up/down ripple counter.
- Resynchronises the counter's ripple output into the system clock domain.
- Filters the transient ripple states with a stability filter.
- Publishes each accepted count with a valid pulse, flags terminal count and wrap-around, accumulates wraps, and checks that each accepted step is +1 (up) or -1 (down) modulo 2^WIDTH.

---
 rtl/ripple_cap_pkg.sv | 22 ++
 rtl/ripple_count_capture_sync_stable_filter.sv | 56 +++++
 rtl/ripple_count_capture.sv | 97 +++++++++
 3 files changed

// File: rtl/ripple_cap_pkg.sv
// Shared constants and the next-count helper for the ripple counter capture block.
package ripple_cap_pkg;

    localparam int unsigned DefaultWidth        = 4;
    localparam int unsigned DefaultStableCycles = 2;
    localparam int unsigned DefaultWrapW        = 8;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    // Next count in the given direction, wrapped to the low 'width' bits (width <= 32).
    function automatic logic [31:0] exp_next(input logic [31:0]    cnt,
                                             input logic           mode,
                                             input int unsigned    width);
        logic [31:0] mask;
        logic [31:0] nxt;
        mask = (width >= 32) ? '1 : ((32'h1 << width) - 32'h1);
        nxt  = (mode == MODE_UP) ? (cnt + 32'h1) : (cnt - 32'h1);
        return nxt & mask;
    endfunction

endpackage

// File: rtl/ripple_count_capture_sync_stable_filter.sv
// Two-flop resynchroniser followed by a stability filter that strobes 'accept' once a new
// value has been seen for STABLE_CYCLES consecutive synchronised samples.
module sync_stable_filter
    import ripple_cap_pkg::*;
#(
    parameter int unsigned WIDTH         = DefaultWidth,
    parameter int unsigned STABLE_CYCLES = DefaultStableCycles
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] cur_cnt,
    output logic             accept,
    output logic [WIDTH-1:0] cand
);

    localparam int unsigned      StabW   = $clog2(STABLE_CYCLES);
    localparam logic [StabW-1:0] StabMax = StabW'(STABLE_CYCLES - 1);
    localparam logic [StabW-1:0] StabHit = StabW'(STABLE_CYCLES - 2);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [StabW-1:0] stab_q, stab_d;
    logic             same;

    always_comb begin
        same   = (s2_q == cand_q);
        cand_d = cand_q;
        stab_d = stab_q;
        if (!same) begin
            cand_d = s2_q;
            stab_d = '0;
        end else if (stab_q != StabMax) begin
            stab_d = stab_q + 1'b1;
        end
        // Fires only on the edge the run length first reaches STABLE_CYCLES.
        accept = same && (stab_q == StabHit) && (cand_q != cur_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            cand_q <= '0;
            stab_q <= '0;
        end else begin
            s1_q   <= cnt_in;
            s2_q   <= s1_q;
            cand_q <= cand_d;
            stab_q <= stab_d;
        end
    end

    assign cand = cand_q;

endmodule

// File: rtl/ripple_count_capture.sv
// Captures an asynchronous ripple counter into the clk domain, publishes accepted counts,
// and tracks terminal count, wrap-arounds and direction-inconsistent steps.
module ripple_count_capture
    import ripple_cap_pkg::*;
#(
    parameter int unsigned WIDTH         = DefaultWidth,
    parameter int unsigned STABLE_CYCLES = DefaultStableCycles,
    parameter int unsigned WRAP_W        = DefaultWrapW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              mode,
    input  logic              err_clr,
    output logic [WIDTH-1:0]  cnt_q,
    output logic              cnt_valid,
    output logic              tc,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              step_err
);

    localparam logic [WIDTH-1:0] CntMax = '1;

    logic              accept;
    logic [WIDTH-1:0]  cand;
    logic [WIDTH-1:0]  cnt_d;
    logic [WIDTH-1:0]  exp_cnt;
    logic              first_seen_q, first_seen_d;
    logic              valid_q, valid_d;
    logic              wrap_q, wrap_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              err_q, err_d;
    logic              step_bad;
    logic              wrap_hit;

    sync_stable_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .cnt_in  (cnt_in),
        .cur_cnt (cnt_q),
        .accept  (accept),
        .cand    (cand)
    );

    always_comb begin
        exp_cnt  = WIDTH'(exp_next(32'(cnt_q), mode, WIDTH));
        // The first accept after reset has no predecessor, so it is neither checked nor a wrap.
        step_bad = accept && first_seen_q && (cand != exp_cnt);
        wrap_hit = accept && first_seen_q &&
                   (((mode == MODE_UP)   && (cnt_q == CntMax) && (cand == '0)) ||
                    ((mode == MODE_DOWN) && (cnt_q == '0)     && (cand == CntMax)));

        cnt_d        = accept ? cand : cnt_q;
        first_seen_d = first_seen_q | accept;
        valid_d      = accept;
        wrap_d       = wrap_hit;

        wrap_cnt_d = wrap_cnt_q;
        if (wrap_hit && (wrap_cnt_q != '1)) begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
        end

        // A new error beats a simultaneous clear.
        err_d = step_bad ? 1'b1 : (err_clr ? 1'b0 : err_q);

        tc = ((mode == MODE_UP)   && (cnt_q == CntMax)) ||
             ((mode == MODE_DOWN) && (cnt_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            first_seen_q <= 1'b0;
            valid_q      <= 1'b0;
            wrap_q       <= 1'b0;
            wrap_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            first_seen_q <= first_seen_d;
            valid_q      <= valid_d;
            wrap_q       <= wrap_d;
            wrap_cnt_q   <= wrap_cnt_d;
            err_q        <= err_d;
        end
    end

    assign cnt_valid  = valid_q;
    assign wrap_pulse = wrap_q;
    assign wrap_count = wrap_cnt_q;
    assign step_err   = err_q;

endmodule
